// File: rtl/corr_peak_detector.sv
// corr_peak_detector: tracks the largest correlation value over a lag window
// and reports it with its first lag index and a threshold-crossing flag.
module corr_peak_detector #(
    parameter int CORR_W  = 16,
    parameter int SAMPLES = 128,
    parameter int IDX_W   = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     corr_valid,
    input  logic signed [CORR_W-1:0] corr_value,
    input  logic signed [CORR_W-1:0] threshold,
    output logic                     busy,
    output logic [IDX_W-1:0]         count,
    output logic                     peak_valid,
    output logic                     peak_found,
    output logic signed [CORR_W-1:0] peak_value,
    output logic [IDX_W-1:0]         peak_index
);

    typedef enum logic [1:0] {
        IDLE,
        SEARCH,
        REPORT
    } state_t;

    localparam logic signed [CORR_W-1:0] MOST_NEG =
        {1'b1, {(CORR_W-1){1'b0}}};
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SAMPLES - 1);

    state_t                   state;
    logic signed [CORR_W-1:0] max_val;
    logic signed [CORR_W-1:0] thr_lat;
    logic [IDX_W-1:0]         max_idx;

    logic signed [CORR_W-1:0] nxt_max;
    logic [IDX_W-1:0]         nxt_idx;
    logic                     take;
    logic                     last;

    // Strict compare so a tie keeps the earlier lag.
    always_comb begin
        take    = corr_value > max_val;
        nxt_max = take ? corr_value : max_val;
        nxt_idx = take ? count : max_idx;
        last    = (count == LAST_IDX);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            busy       <= 1'b0;
            count      <= '0;
            peak_valid <= 1'b0;
            peak_found <= 1'b0;
            peak_value <= '0;
            peak_index <= '0;
            max_val    <= MOST_NEG;
            max_idx    <= '0;
            thr_lat    <= '0;
        end else begin
            peak_valid <= 1'b0;
            unique case (state)
                IDLE, SEARCH: begin
                    if (start) begin
                        state   <= SEARCH;
                        busy    <= 1'b1;
                        count   <= '0;
                        max_val <= MOST_NEG;
                        max_idx <= '0;
                        thr_lat <= threshold;
                    end else if (state == SEARCH && corr_valid) begin
                        max_val <= nxt_max;
                        max_idx <= nxt_idx;
                        count   <= count + 1'b1;
                        if (last) begin
                            state      <= REPORT;
                            busy       <= 1'b0;
                            peak_valid <= 1'b1;
                            peak_value <= nxt_max;
                            peak_index <= nxt_idx;
                            peak_found <= (nxt_max >= thr_lat);
                        end
                    end
                end
                REPORT: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_corr_peak_detector.sv
// tb_corr_peak_detector: randomized windows checked every cycle against a
// queue-based window model, plus literal expectations per scenario.
module tb_corr_peak_detector;

    localparam int CW = 16;
    localparam int NS = 128;
    localparam int IW = 8;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b1;
    logic                 start = 1'b0;
    logic                 corr_valid = 1'b0;
    logic signed [CW-1:0] corr_value = '0;
    logic signed [CW-1:0] threshold = '0;
    logic                 busy;
    logic [IW-1:0]        count;
    logic                 peak_valid;
    logic                 peak_found;
    logic signed [CW-1:0] peak_value;
    logic [IW-1:0]        peak_index;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    corr_peak_detector #(
        .CORR_W (CW),
        .SAMPLES(NS),
        .IDX_W  (IW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .corr_valid(corr_valid),
        .corr_value(corr_value),
        .threshold (threshold),
        .busy      (busy),
        .count     (count),
        .peak_valid(peak_valid),
        .peak_found(peak_found),
        .peak_value(peak_value),
        .peak_index(peak_index)
    );

    // Window model: accepted values in a queue, result from the whole window.
    bit m_open = 0;
    bit m_rep = 0;
    int m_thr = 0;
    int win[$];
    bit e_busy = 0;
    bit e_pv = 0;
    bit e_pf = 0;
    int e_count = 0;
    int e_val = 0;
    int e_idx = 0;

    int n_pv = 0;
    int cap_val = 0;
    int cap_idx = 0;
    int cap_found = 0;

    task automatic chk(string name, longint act, longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual %0d required %0d", name, act, exp);
        end
    endtask

    task automatic finish_window();
        int m;
        int idx;
        m = win[0];
        foreach (win[i]) if (win[i] > m) m = win[i];
        idx = -1;
        foreach (win[i]) if (win[i] == m && idx < 0) idx = i;
        m_open = 0;
        m_rep  = 1;
        e_busy = 0;
        e_pv   = 1;
        e_val  = m;
        e_idx  = idx;
        e_pf   = (m >= m_thr);
    endtask

    task automatic model_step();
        if (!rst_n) begin
            m_open = 0; m_rep = 0; m_thr = 0;
            win.delete();
            e_busy = 0; e_pv = 0; e_pf = 0;
            e_count = 0; e_val = 0; e_idx = 0;
        end else begin
            e_pv = 0;
            if (m_rep) begin
                m_rep = 0;
            end else if (start) begin
                m_open = 1;
                win.delete();
                m_thr = int'(threshold);
                e_busy = 1;
                e_count = 0;
            end else if (m_open && corr_valid) begin
                win.push_back(int'(corr_value));
                e_count = win.size();
                if (win.size() == NS) finish_window();
            end
        end
    endtask

    always @(posedge clk) begin
        model_step();
        #1;
        chk("busy", busy, e_busy);
        chk("count", count, e_count);
        chk("peak_valid", peak_valid, e_pv);
        chk("peak_value", peak_value, e_val);
        chk("peak_index", peak_index, e_idx);
        chk("peak_found", peak_found, e_pf);
        if (peak_valid) begin
            n_pv++;
            cap_val   = int'(peak_value);
            cap_idx   = int'(peak_index);
            cap_found = int'(peak_found);
        end
    end

    task automatic drive(bit s, bit v, int val);
        @(negedge clk);
        start = s;
        corr_valid = v;
        corr_value = CW'(val);
    endtask

    task automatic send(int val, int gap_pct);
        while (int'($urandom_range(99)) < gap_pct) drive(0, 0, int'($urandom));
        drive(0, 1, val);
    endtask

    task automatic idle(int n);
        repeat (n) drive(0, 0, 0);
    endtask

    // A valid max-positive value rides along with start; it must not count.
    task automatic begin_window(int thr);
        @(negedge clk);
        threshold  = CW'(thr);
        start      = 1'b1;
        corr_valid = 1'b1;
        corr_value = 16'sh7fff;
    endtask

    task automatic expect_result(string tag, int val, int idx, int found,
                                 int pv_before);
        chk({tag, "_pv_count"}, n_pv - pv_before, 1);
        chk({tag, "_value"}, cap_val, val);
        chk({tag, "_index"}, cap_idx, idx);
        chk({tag, "_found"}, cap_found, found);
    endtask

    task automatic ramp(string tag);
        int p;
        p = n_pv;
        begin_window(100);
        for (int i = 0; i < NS; i++) send(i, 0);
        drive(1, 1, 32767);
        idle(3);
        expect_result(tag, 127, 127, 1, p);
        chk({tag, "_count"}, count, 128);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int p;
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_count", count, 0);
        chk("rst_peak_valid", peak_valid, 0);
        chk("rst_peak_value", peak_value, 0);
        rst_n = 1'b1;
        idle(2);

        ramp("ramp");

        p = n_pv;
        begin_window(400);
        for (int i = 0; i < NS; i++) send(i == 37 ? 500 : 0, 0);
        idle(3);
        expect_result("spike_lo", 500, 37, 1, p);

        p = n_pv;
        begin_window(600);
        for (int i = 0; i < NS; i++) send(i == 37 ? 500 : 0, 0);
        idle(3);
        expect_result("spike_hi", 500, 37, 0, p);

        p = n_pv;
        begin_window(0);
        for (int i = 0; i < NS; i++) send(-5, 0);
        idle(3);
        expect_result("all_neg", -5, 0, 0, p);

        p = n_pv;
        begin_window(0);
        for (int i = 0; i < NS; i++)
            send((i == 10 || i == 90) ? 200 : int'($urandom_range(399)) - 200, 0);
        idle(3);
        expect_result("tie", 200, 10, 1, p);

        p = n_pv;
        begin_window(250);
        for (int i = 0; i < NS; i++) begin
            if (i == 40) threshold = 16'sd1000;
            send(i == 64 ? 300 : int'($urandom_range(599)) - 300, 50);
        end
        idle(3);
        expect_result("gapped", 300, 64, 1, p);

        p = n_pv;
        begin_window(0);
        for (int i = 0; i < 50; i++) send(i == 20 ? 900 : int'($urandom_range(99)), 0);
        begin_window(0);
        for (int i = 0; i < NS; i++)
            send(i == 5 ? 40 : int'($urandom_range(139)) - 100, 20);
        idle(3);
        expect_result("restart", 40, 5, 1, p);

        p = n_pv;
        begin_window(0);
        for (int i = 0; i < 70; i++) send(i, 0);
        @(negedge clk);
        corr_valid = 1'b0;
        #3 rst_n = 1'b0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_count", count, 0);
        chk("arst_peak_valid", peak_valid, 0);
        chk("arst_peak_value", peak_value, 0);
        chk("arst_peak_index", peak_index, 0);
        chk("arst_peak_found", peak_found, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        idle(2);
        chk("arst_no_pv", n_pv - p, 0);
        ramp("ramp_after_rst");

        for (int w = 0; w < 4; w++) begin
            begin_window(int'($urandom_range(65535)) - 32768);
            for (int i = 0; i < NS; i++) begin
                if (i == 30) threshold = CW'($urandom);
                send(int'($urandom_range(65535)) - 32768, 30);
            end
            idle(3);
        end

        idle(3);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
